// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags and an optional iterative shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise op 5 completes as an illegal op.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             cf,
    output logic             ill
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_PASS = 4'd6;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam int         CNTW    = $clog2(WIDTH) + 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef SEQ_ALU_MUL_EN
        ,
        S_MUL  = 2'd2
`endif
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zf_q;
    logic             cf_q;
    logic             ill_q;

    logic [WIDTH-1:0] alu_res_d;
    logic             alu_cf_d;
    logic             alu_ill_d;
    logic             alu_zf_d;

    // Single-cycle result computed straight from the inputs presented at the accept edge.
    always_comb begin
        alu_res_d = '0;
        alu_cf_d  = 1'b0;
        alu_ill_d = 1'b0;
        unique case (op)
            OP_AND:  alu_res_d = in0 & in1;
            OP_OR:   alu_res_d = in0 | in1;
            OP_ADD:  {alu_cf_d, alu_res_d} = {1'b0, in0} + {1'b0, in1};
            OP_SUB: begin
                alu_res_d = in1 - in0;
                alu_cf_d  = (in0 > in1);
            end
            OP_CMP:  alu_res_d = {{(WIDTH-1){1'b0}}, (in0 == in1)};
            OP_PASS: alu_res_d = in0;
            default: alu_ill_d = 1'b1;
        endcase
        alu_zf_d = (alu_res_d == '0);
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNTW-1:0]  cnt_q;
    logic             mul_last;
    logic             mul_start;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (cnt_q == CNTW'(WIDTH - 1));
    assign mul_start = (state_q == S_IDLE) && in_valid && (op == OP_MUL);

    // Multiplier datapath carries no reset; the FSM decides when its contents matter.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand_q  <= in0;
            mplier_q <= in1;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + CNTW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zf_q        <= 1'b1;
            cf_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            state_q <= S_MUL;
                        end else
`endif
                        begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_q       <= alu_res_d;
                            zf_q        <= alu_zf_d;
                            cf_q        <= alu_cf_d;
                            ill_q       <= alu_ill_d;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    if (mul_last) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= acc_d;
                        zf_q        <= (acc_d == '0);
                        cf_q        <= 1'b0;
                        ill_q       <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign ill       = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH=8) against an arithmetic reference model.
// Follows SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zf;
    logic         cf;
    logic         ill;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out       (out),
        .zf        (zf),
        .cf        (cf),
        .ill       (ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op table.
    task automatic model(input int o, input int a, input int b,
                         output int eo, output int ecf, output int eill, output int elat);
        eo = 0; ecf = 0; eill = 0; elat = 1;
        case (o)
            0: eo = a & b;
            1: eo = a | b;
            2: begin eo = (a + b) % 256; ecf = (a + b > 255) ? 1 : 0; end
            3: begin eo = (b - a + 256) % 256; ecf = (a > b) ? 1 : 0; end
            4: eo = (a == b) ? 1 : 0;
`ifdef SEQ_ALU_MUL_EN
            5: begin eo = (a * b) % 256; elat = W + 1; end
`endif
            6: eo = a;
            default: eill = 1;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the result pulse.
    task automatic run_op(input string nm, input int o, input int a, input int b);
        int eo, ecf, eill, elat, lat, guard, busy_bad;
        model(o, a, b, eo, ecf, eill, elat);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op  = 4'(o);
        in0 = 8'(a);
        in1 = 8'(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op  = 4'($urandom);
        in0 = 8'($urandom);
        in1 = 8'($urandom);
        lat = 1;
        busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"},  32'(lat),  32'(elat));
        chk({nm, "_busy"}, 32'(busy_bad), 32'd0);
        chk({nm, "_out"},  32'(out),  32'(eo));
        chk({nm, "_zf"},   32'(zf),   (eo == 0) ? 32'd1 : 32'd0);
        chk({nm, "_cf"},   32'(cf),   32'(ecf));
        chk({nm, "_ill"},  32'(ill),  32'(eill));
        chk({nm, "_rdy_done"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, 32'(out_valid), 32'd0);
        chk({nm, "_hold"},  32'(out), 32'(eo));
        chk({nm, "_rdy"},   32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int o, a, b, seen;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; in0 = '0; in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ov",    32'(out_valid), 32'd0);
        chk("rst_out",   32'(out), 32'd0);
        chk("rst_zf",    32'(zf), 32'd1);
        chk("rst_cf",    32'(cf), 32'd0);
        chk("rst_ill",   32'(ill), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_carry", 2, 8'hF0, 8'h20);
        run_op("sub_eq",    3, 5, 5);
        run_op("sub_borrow", 3, 6, 5);
        run_op("mul_13_11", 5, 13, 11);
        run_op("mul_ff",    5, 8'hFF, 8'hFF);
        run_op("illegal_f", 15, 8'h3C, 8'hA5);
        run_op("cmp_eq",    4, 7, 7);
        run_op("cmp_ne",    4, 7, 8);
        run_op("and",       0, 8'hCA, 8'h0F);
        run_op("or",        1, 8'h50, 8'h0A);
        run_op("pass",      6, 8'h81, 8'h00);

        // Abort a multiply at its fourth step; a nonzero result is loaded first.
        run_op("pre_abort", 2, 8'h10, 8'h01);
        in_valid = 1'b1; op = 4'd5; in0 = 8'd13; in1 = 8'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_ov",    32'(out_valid), 32'd0);
        chk("abort_out",   32'(out), 32'd0);
        chk("abort_zf",    32'(zf), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);

        // Reset coinciding with a request wins.
        run_op("pre_rstwin", 6, 8'h77, 8'h00);
        in_valid = 1'b1; op = 4'd2; in0 = 8'd1; in1 = 8'd2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstwin_ready", 32'(in_ready), 32'd1);
        chk("rstwin_ov",    32'(out_valid), 32'd0);
        chk("rstwin_out",   32'(out), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstwin_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 80; i++) begin
            o = int'($urandom_range(0, 15));
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 255));
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
